nametable_fetch_addr_gen: RTL and testbench
===========================================

// Module: nametable_fetch_addr_gen
// PURPOSE
//  Pipelined background address generator for the PPU fetch path. Maps a screen pixel
//  (row, col) plus a frame-latched scroll and nametable select to the tile, attribute
//  and pattern-row addresses. Handles 240-row vertical wrap, selectable mirroring
//  and valid/ready flow control. Sits between the scanline pixel sequencer and the
//  VRAM fetch arbiter.
// PARAMETERS
//  NT_BASE        16'h2000  base address of nametable 0
//  NT_SIZE        16'h0400  stride between physical nametables
//  AT_OFFSET      16'h03C0  attribute table offset inside a nametable
//  ROWS           240       visible rows per nametable (vertical wrap point)
//  DEFAULT_MIRROR 2'd1      mirror mode loaded at reset
// PORTS
//  clk                   in   1   clock
//  rst                   in   1   synchronous active-high reset
//  scroll_load           in   1   latch scroll/ctrl/mirror (frame start)
//  cpu_scroll_addr       in   16  [15:8] scroll_y, [7:0] scroll_x
//  ppu_ctrl1             in   8   [1] vertical NT select, [2] horizontal NT select
//  mirror_mode           in   2   0 horiz, 1 vert, 2 single-screen, 3 four-screen
//  in_valid              in   1   pixel request valid
//  in_ready              out  1   request accepted when in_valid && in_ready
//  screen_pixel_row      in   9   screen row, 0..239
//  screen_pixel_col      in   9   screen col, 0..255
//  out_valid             out  1   result valid
//  out_ready             in   1   consumer accepts when out_valid && out_ready
//  nametable_ptr         out  16  tile byte address
//  attr_ptr              out  16  attribute byte address
//  attr_shift            out  3   bit shift of 2-bit palette in attribute byte: 0/2/4/6
//  pattern_table_offset  out  3   fine Y: row within tile
//  fine_x                out  3   col within tile
// BEHAVIOUR
//  Reset: all outputs 0, out_valid=0, pipeline flushed, scroll regs 0,
//   NT select regs 0, mirror reg=DEFAULT_MIRROR. in_ready=1 the cycle after reset.
//   Reset mid-operation discards in-flight requests.
//  Config regs:
//   - On scroll_load, latch scroll_y, scroll_x, ctrl1[1] (v0), ctrl1[2] (h0) and mirror_mode.
//   - A request accepted in the same cycle as scroll_load uses the OLD values.
//   - Requests already in flight are never affected by scroll_load.
//  Pipeline: 2 stages, global advance enable en = !out_valid || out_ready.
//   - in_ready = en.
//   - Accepted at edge N -> out_valid at edge N+2 if not stalled.
//   - Outputs hold stable while out_valid && !out_ready.
//   - No drop, no duplicate, in-order.
//  Stage 1: wrap.
//   - y_sum = row + scroll_y (10b). If scroll_y < ROWS: if y_sum >= ROWS then
//     y = y_sum-ROWS, v = !v0; else y = y_sum, v = v0.
//   - If scroll_y >= ROWS: y = y_sum[7:0], v = v0 ^ (y_sum >= 256).
//   - x_sum = col + scroll_x. x = x_sum[7:0], h = h0 ^ x_sum[8].
//  Stage 2: mirror.
//   - Mirror select nt: mode 0 -> {v,0}, mode 1 -> {0,h}, mode 2 -> 2'b00, mode 3 -> {v,h}.
//  Stage 2: addresses.
//   - nt_base = NT_BASE + nt*NT_SIZE.
//   - nametable_ptr = nt_base + y[7:3]*32 + x[7:3].
//   - attr_ptr = nt_base + AT_OFFSET + y[7:5]*8 + x[7:5].
//   - attr_shift = {y[4], x[4], 1'b0}.
//   - pattern_table_offset = y[2:0]; fine_x = x[2:0].
//  All address arithmetic is 16b, modulo 2^16.
// TESTING
//  1. Reset with in_valid=1 -> out_valid=0, all outputs 0; in_ready=1 next cycle.
//  2. Scroll 0, mode 3, row=100 col=200 -> after 2 cycles: nametable_ptr=16'h2199,
//     attr_ptr=16'h23DE, attr_shift=0, pattern_table_offset=4, fine_x=0.
//  3. scroll_y=16, scroll_x=8, ctrl1=0, mode 3; row=230 col=250 -> nametable_ptr=16'h2C00,
//     attr_ptr=16'h2FC0, pattern_table_offset=6, fine_x=2.
//     Same request with mode 1 -> 16'h2400; mode 0 -> 16'h2800; mode 2 -> 16'h2000.
//  4. scroll_y=248, mode 3; row=10 col=0 -> y=2, v toggled: nametable_ptr=16'h2800,
//     pattern_table_offset=2.
//  5. Stream 4 requests, hold out_ready=0 for 3 cycles -> in_ready=0 while stalled,
//     outputs stable; results emerge in order, no loss or duplicate.
//  6. Assert scroll_load with new scroll in the same cycle as an accepted request ->
//     that request uses the old scroll; the next request uses the new scroll.

Source files
------------

// File: rtl/nametable_fetch_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : nametable_fetch_addr_gen
// Description : Two-stage background fetch address generator. Applies scroll
//               and 240-row vertical wrap, resolves nametable mirroring, and
//               produces tile, attribute and pattern-row addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module nametable_fetch_addr_gen #(
    parameter logic [15:0] NT_BASE        = 16'h2000,
    parameter logic [15:0] NT_SIZE        = 16'h0400,
    parameter logic [15:0] AT_OFFSET      = 16'h03C0,
    parameter int          ROWS           = 240,
    parameter logic [1:0]  DEFAULT_MIRROR = 2'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scroll_load,
    input  logic [15:0] cpu_scroll_addr,
    input  logic [7:0]  ppu_ctrl1,
    input  logic [1:0]  mirror_mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  screen_pixel_row,
    input  logic [8:0]  screen_pixel_col,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] nametable_ptr,
    output logic [15:0] attr_ptr,
    output logic [2:0]  attr_shift,
    output logic [2:0]  pattern_table_offset,
    output logic [2:0]  fine_x
);

    localparam logic [9:0] c_rows    = ROWS[9:0];
    localparam logic [7:0] c_rows_lo = ROWS[7:0];

    // Frame-latched configuration
    logic [7:0] r_scroll_y;
    logic [7:0] r_scroll_x;
    logic       r_v0;
    logic       r_h0;
    logic [1:0] r_mirror;

    // Stage 1 register: wrapped coordinates plus the mirror mode they were accepted with
    logic       r_s1_valid;
    logic [7:0] r_s1_y;
    logic [7:0] r_s1_x;
    logic       r_s1_v;
    logic       r_s1_h;
    logic [1:0] r_s1_mirror;

    logic       w_en;
    logic [9:0] w_y_sum;
    logic [8:0] w_x_sum;
    logic [7:0] w_y;
    logic       w_v;
    logic [1:0] w_nt;
    logic [15:0] w_nt_base;
    logic [15:0] w_nt_ptr;
    logic [15:0] w_attr_ptr;
    logic       w_unused_ctrl;

    assign w_unused_ctrl = ^{ppu_ctrl1[7:3], ppu_ctrl1[0]};

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    assign w_y_sum = {1'b0, screen_pixel_row} + {2'b00, r_scroll_y};
    assign w_x_sum = screen_pixel_col + {1'b0, r_scroll_x};

    // Out-of-range scroll_y (>= ROWS) wraps at 256 instead of at ROWS
    always_comb begin
        w_y = w_y_sum[7:0];
        w_v = r_v0;
        if ({2'b00, r_scroll_y} < c_rows) begin
            if (w_y_sum >= c_rows) begin
                w_y = w_y_sum[7:0] - c_rows_lo;
                w_v = !r_v0;
            end
        end else begin
            w_v = r_v0 ^ (w_y_sum >= 10'd256);
        end
    end

    always_comb begin
        w_nt = {r_s1_v, r_s1_h};
        case (r_s1_mirror)
            2'd0:    w_nt = {r_s1_v, 1'b0};
            2'd1:    w_nt = {1'b0, r_s1_h};
            2'd2:    w_nt = 2'b00;
            default: w_nt = {r_s1_v, r_s1_h};
        endcase
    end

    assign w_nt_base  = NT_BASE + NT_SIZE * {14'd0, w_nt};
    assign w_nt_ptr   = w_nt_base + {6'd0, r_s1_y[7:3], 5'd0} + {11'd0, r_s1_x[7:3]};
    assign w_attr_ptr = w_nt_base + AT_OFFSET + {10'd0, r_s1_y[7:5], 3'd0}
                        + {13'd0, r_s1_x[7:5]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scroll_y           <= 8'd0;
            r_scroll_x           <= 8'd0;
            r_v0                 <= 1'b0;
            r_h0                 <= 1'b0;
            r_mirror             <= DEFAULT_MIRROR;
            r_s1_valid           <= 1'b0;
            r_s1_y               <= 8'd0;
            r_s1_x               <= 8'd0;
            r_s1_v               <= 1'b0;
            r_s1_h               <= 1'b0;
            r_s1_mirror          <= 2'd0;
            out_valid            <= 1'b0;
            nametable_ptr        <= 16'd0;
            attr_ptr             <= 16'd0;
            attr_shift           <= 3'd0;
            pattern_table_offset <= 3'd0;
            fine_x               <= 3'd0;
        end else begin
            // A request accepted this edge already sampled the old config values
            if (scroll_load) begin
                r_scroll_y <= cpu_scroll_addr[15:8];
                r_scroll_x <= cpu_scroll_addr[7:0];
                r_v0       <= ppu_ctrl1[1];
                r_h0       <= ppu_ctrl1[2];
                r_mirror   <= mirror_mode;
            end
            if (w_en) begin
                r_s1_valid           <= in_valid;
                r_s1_y               <= w_y;
                r_s1_x               <= w_x_sum[7:0];
                r_s1_v               <= w_v;
                r_s1_h               <= r_h0 ^ w_x_sum[8];
                r_s1_mirror          <= r_mirror;
                out_valid            <= r_s1_valid;
                nametable_ptr        <= w_nt_ptr;
                attr_ptr             <= w_attr_ptr;
                attr_shift           <= {r_s1_y[4], r_s1_x[4], 1'b0};
                pattern_table_offset <= r_s1_y[2:0];
                fine_x               <= r_s1_x[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nametable_fetch_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nametable_fetch_addr_gen
// Description : Directed and random checks of nametable_fetch_addr_gen
//               against an arithmetic reference model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nametable_fetch_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scroll_load = 1'b0;
    logic [15:0] cpu_scroll_addr = 16'd0;
    logic [7:0]  ppu_ctrl1 = 8'd0;
    logic [1:0]  mirror_mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  screen_pixel_row = 9'd0;
    logic [8:0]  screen_pixel_col = 9'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] nametable_ptr;
    logic [15:0] attr_ptr;
    logic [2:0]  attr_shift;
    logic [2:0]  pattern_table_offset;
    logic [2:0]  fine_x;

    nametable_fetch_addr_gen dut (
        .clk                  (clk),
        .rst                  (rst),
        .scroll_load          (scroll_load),
        .cpu_scroll_addr      (cpu_scroll_addr),
        .ppu_ctrl1            (ppu_ctrl1),
        .mirror_mode          (mirror_mode),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .screen_pixel_row     (screen_pixel_row),
        .screen_pixel_col     (screen_pixel_col),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .nametable_ptr        (nametable_ptr),
        .attr_ptr             (attr_ptr),
        .attr_shift           (attr_shift),
        .pattern_table_offset (pattern_table_offset),
        .fine_x               (fine_x)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] nt;
        logic [15:0] at;
        logic [2:0]  sh;
        logic [2:0]  pto;
        logic [2:0]  fx;
    } exp_t;

    exp_t        q[$];
    logic [15:0] pop_nt[$];
    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    int          popped = 0;
    int          m_sy = 0, m_sx = 0, m_v0 = 0, m_h0 = 0, m_mode = 1;
    bit          stall_prev = 0;
    logic [40:0] snap;
    bit          last_acc;
    bit          last_take;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Screen-space reference: wrap in whole nametables, then index 8x8 tiles / 32x32 attr blocks
    function automatic exp_t model(int row, int col);
        exp_t e;
        int ys, xs, y, x, v, h, nt, base;
        ys = row + m_sy;
        if (m_sy < 240) begin
            if (ys >= 240) begin y = ys - 240; v = 1 - m_v0; end
            else begin y = ys; v = m_v0; end
        end else begin
            y = ys % 256;
            v = (ys >= 256) ? 1 - m_v0 : m_v0;
        end
        xs = col + m_sx;
        x  = xs % 256;
        h  = (xs >= 256) ? 1 - m_h0 : m_h0;
        case (m_mode)
            0: nt = v * 2;
            1: nt = h;
            2: nt = 0;
            default: nt = v * 2 + h;
        endcase
        base  = 'h2000 + nt * 'h400;
        e.nt  = 16'((base + (y / 8) * 32 + x / 8) % 65536);
        e.at  = 16'((base + 'h3C0 + (y / 32) * 8 + x / 32) % 65536);
        e.sh  = 3'(((y / 16) % 2) * 4 + ((x / 16) % 2) * 2);
        e.pto = 3'(y % 8);
        e.fx  = 3'(x % 8);
        return e;
    endfunction

    // One clock: observe just after the falling edge, update scoreboard, advance
    task automatic tick();
        exp_t e;
        #1;
        last_acc  = 0;
        last_take = 0;
        if (rst) begin
            q.delete();
            stall_prev = 0;
            m_sy = 0; m_sx = 0; m_v0 = 0; m_h0 = 0; m_mode = 1;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", 64'(out_valid), 64'd1);
                chk("stall_outputs_stable",
                    64'({nametable_ptr, attr_ptr, attr_shift, pattern_table_offset, fine_x}),
                    64'(snap));
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
            last_acc  = in_valid && in_ready;
            last_take = out_valid && out_ready;
            if (last_take) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("nametable_ptr", 64'(nametable_ptr), 64'(e.nt));
                    chk("attr_ptr", 64'(attr_ptr), 64'(e.at));
                    chk("attr_shift", 64'(attr_shift), 64'(e.sh));
                    chk("pattern_table_offset", 64'(pattern_table_offset), 64'(e.pto));
                    chk("fine_x", 64'(fine_x), 64'(e.fx));
                end
                pop_nt.push_back(nametable_ptr);
                popped++;
            end
            if (last_acc) begin
                q.push_back(model(int'(screen_pixel_row), int'(screen_pixel_col)));
                accepted++;
            end
            if (scroll_load) begin
                m_sy = int'(cpu_scroll_addr[15:8]);
                m_sx = int'(cpu_scroll_addr[7:0]);
                m_v0 = int'(ppu_ctrl1[1]);
                m_h0 = int'(ppu_ctrl1[2]);
                m_mode = int'(mirror_mode);
            end
            stall_prev = out_valid && !out_ready;
            snap = {nametable_ptr, attr_ptr, attr_shift, pattern_table_offset, fine_x};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_cfg(input logic [7:0] sy, input logic [7:0] sx,
                            input logic [7:0] ctrl, input logic [1:0] mode);
        scroll_load = 1; cpu_scroll_addr = {sy, sx}; ppu_ctrl1 = ctrl; mirror_mode = mode;
        tick();
        scroll_load = 0;
    endtask

    // Send one request into an idle pipeline and confirm two-cycle latency
    task automatic send_one(input int row, input int col);
        int lat;
        int start_pop;
        bit got;
        start_pop = popped;
        in_valid = 1;
        screen_pixel_row = 9'(row);
        screen_pixel_col = 9'(col);
        tick();
        chk("send_accepted", 64'(last_acc), 64'd1);
        in_valid = 0;
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            lat++;
            tick();
            got = (popped != start_pop);
        end
        chk("latency", 64'(lat), 64'd2);
    endtask

    initial begin
        int c;
        // Reset with a request pending
        rst = 1; in_valid = 1; screen_pixel_row = 9'd5; screen_pixel_col = 9'd7;
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({nametable_ptr, attr_ptr, attr_shift, pattern_table_offset, fine_x}), 64'd0);
        rst = 0; in_valid = 0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Zero scroll, four-screen
        load_cfg(8'd0, 8'd0, 8'd0, 2'd3);
        send_one(100, 200);
        chk("t2_nt", 64'(pop_nt[$]), 64'h2199);

        // Vertical and horizontal wrap under each mirror mode
        load_cfg(8'd16, 8'd8, 8'd0, 2'd3);
        send_one(230, 250);
        chk("t3_nt_mode3", 64'(pop_nt[$]), 64'h2C00);
        load_cfg(8'd16, 8'd8, 8'd0, 2'd1);
        send_one(230, 250);
        chk("t3_nt_mode1", 64'(pop_nt[$]), 64'h2400);
        load_cfg(8'd16, 8'd8, 8'd0, 2'd0);
        send_one(230, 250);
        chk("t3_nt_mode0", 64'(pop_nt[$]), 64'h2800);
        load_cfg(8'd16, 8'd8, 8'd0, 2'd2);
        send_one(230, 250);
        chk("t3_nt_mode2", 64'(pop_nt[$]), 64'h2000);

        // Out-of-range scroll_y wraps at 256
        load_cfg(8'd248, 8'd0, 8'd0, 2'd3);
        send_one(10, 0);
        chk("t4_nt", 64'(pop_nt[$]), 64'h2800);

        // Stream of four with a three-cycle consumer stall
        load_cfg(8'd3, 8'd77, 8'h06, 2'd3);
        begin
            int base_acc, base_pop;
            base_acc = accepted;
            base_pop = popped;
            c = 0;
            while ((accepted - base_acc < 4 || popped - base_pop < 4) && c < 40) begin
                in_valid = (accepted - base_acc < 4);
                screen_pixel_row = 9'(40 + 30 * (accepted - base_acc));
                screen_pixel_col = 9'(17 * (accepted - base_acc));
                out_ready = !(c >= 2 && c < 5);
                tick();
                c++;
            end
            in_valid = 0; out_ready = 1;
            chk("t5_pops", 64'(popped - base_pop), 64'd4);
        end

        // scroll_load coincident with an accepted request
        load_cfg(8'd0, 8'd0, 8'd0, 2'd3);
        in_valid = 1; screen_pixel_row = 9'd100; screen_pixel_col = 9'd200;
        scroll_load = 1; cpu_scroll_addr = {8'd16, 8'd8}; ppu_ctrl1 = 8'd0; mirror_mode = 2'd3;
        tick();
        chk("t6_accept", 64'(last_acc), 64'd1);
        scroll_load = 0;
        tick();
        in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_old_scroll", 64'(pop_nt[pop_nt.size() - 2]), 64'h2199);
        chk("t6_new_scroll", 64'(pop_nt[$]), 64'h21DA);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            rst = (i == 200);
            in_valid = ($urandom_range(0, 3) != 0);
            screen_pixel_row = 9'($urandom_range(0, 239));
            screen_pixel_col = 9'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 9) < 7);
            scroll_load = ($urandom_range(0, 19) == 0);
            cpu_scroll_addr = 16'($urandom_range(0, 65535));
            ppu_ctrl1 = 8'($urandom_range(0, 255));
            mirror_mode = 2'($urandom_range(0, 3));
            tick();
            if (i == 200) chk("midrst_out_valid", 64'(out_valid), 64'd0);
        end
        rst = 0; scroll_load = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
